// File: rtl/hqc_params_pkg.sv
// Per-parameter-set constants, derived widths and FSM states for the HQC
// fixed-weight position sampler.
package hqc_params_pkg;

  typedef enum logic [1:0] {HQC128, HQC192, HQC256} param_set_e;

  typedef enum logic [2:0] {IDLE, FETCH, REDUCE, CHECK, EMIT, FIN} state_e;

  function automatic int unsigned set_n(input param_set_e ps);
    case (ps)
      HQC128:  return 17669;
      HQC192:  return 35851;
      default: return 57637;
    endcase
  endfunction

  function automatic int unsigned set_w(input param_set_e ps);
    case (ps)
      HQC128:  return 66;
      HQC192:  return 100;
      default: return 131;
    endcase
  endfunction

  // Barrett constant floor(2^32 / N)
  function automatic int unsigned set_k(input param_set_e ps);
    case (ps)
      HQC128:  return 243079;
      HQC192:  return 119800;
      default: return 74517;
    endcase
  endfunction

  function automatic int set_kw(input param_set_e ps);
    case (ps)
      HQC128:  return 18;
      default: return 17;
    endcase
  endfunction

  // Words at or above K*N would bias the residue distribution.
  function automatic logic [31:0] set_limit(input param_set_e ps);
    return 32'(64'(set_k(ps)) * 64'(set_n(ps)));
  endfunction

  function automatic int pos_w(input param_set_e ps);
    return $clog2(set_n(ps));
  endfunction

  function automatic int idx_w(input param_set_e ps);
    return $clog2(set_w(ps));
  endfunction

  function automatic int cnt_w(input param_set_e ps);
    return $clog2(set_w(ps) + 1);
  endfunction

endpackage

// File: rtl/fixed_weight_pos_gen_if.sv
// Random-word input stream and position output stream of the fixed-weight
// sampler; slave is the sampler side.
interface fixed_weight_pos_gen_if
  import hqc_params_pkg::*;
#(
  parameter param_set_e parameter_set = HQC256
);
  localparam int PW = pos_w(parameter_set);
  localparam int IW = idx_w(parameter_set);

  logic          start;
  logic [31:0]   rand_in;
  logic          rand_valid;
  logic          rand_ready;
  logic [PW-1:0] pos_out;
  logic [IW-1:0] pos_idx;
  logic          pos_valid;
  logic          busy;
  logic          done;

  modport master (
    output start, rand_in, rand_valid,
    input  rand_ready, pos_out, pos_idx, pos_valid, busy, done
  );

  modport slave (
    input  start, rand_in, rand_valid,
    output rand_ready, pos_out, pos_idx, pos_valid, busy, done
  );

endinterface

// File: rtl/barrett_mod_n.sv
// Three-stage pipelined Barrett reduction of a 32-bit word modulo N, with a
// bias-rejection flag that travels alongside the residue.
module barrett_mod_n
  import hqc_params_pkg::*;
#(
  parameter param_set_e parameter_set = HQC256,
  localparam int PW = pos_w(parameter_set)
)
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_valid,
  input  logic [31:0]   a,
  output logic          r_valid,
  output logic [PW-1:0] r,
  output logic          reject
);
  localparam int unsigned N     = set_n(parameter_set);
  localparam int          KW    = set_kw(parameter_set);
  localparam logic [KW-1:0] K_C = KW'(set_k(parameter_set));
  localparam logic [31:0] N32   = 32'(N);
  localparam logic [PW:0] N_C   = (PW+1)'(N);
  localparam logic [31:0] LIMIT = set_limit(parameter_set);

  logic          s1_valid, s1_reject;
  logic [31:0]   s1_a;
  logic [KW-1:0] s1_t;
  logic          s2_valid, s2_reject;
  logic [PW:0]   s2_c;

  // Floored K keeps c in [0, 2N), so one conditional subtract finishes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_reject <= 1'b0;
      s1_a      <= '0;
      s1_t      <= '0;
      s2_valid  <= 1'b0;
      s2_reject <= 1'b0;
      s2_c      <= '0;
      r_valid   <= 1'b0;
      reject    <= 1'b0;
      r         <= '0;
    end else begin
      s1_valid  <= a_valid;
      s1_reject <= (a >= LIMIT);
      s1_a      <= a;
      s1_t      <= KW'((64'(a) * 64'(K_C)) >> 32);
      s2_valid  <= s1_valid;
      s2_reject <= s1_reject;
      s2_c      <= (PW+1)'(s1_a - 32'(s1_t) * N32);
      r_valid   <= s2_valid;
      reject    <= s2_reject;
      r         <= (s2_c >= N_C) ? PW'(s2_c - N_C) : PW'(s2_c);
    end
  end

endmodule

// File: rtl/fixed_weight_pos_gen.sv
// Fixed-weight support sampler: reduces random words mod N, drops biased and
// duplicate candidates, and emits W distinct positions in [0, N).
module fixed_weight_pos_gen
  import hqc_params_pkg::*;
#(
  parameter param_set_e parameter_set = HQC256
)
(
  input  logic                    clk,
  input  logic                    rst_n,
  fixed_weight_pos_gen_if.slave   bus
);
  localparam int W  = int'(set_w(parameter_set));
  localparam int PW = pos_w(parameter_set);
  localparam int IW = idx_w(parameter_set);
  localparam int CW = cnt_w(parameter_set);

  state_e        state;
  logic [CW-1:0] count;
  logic [CW-1:0] chk_idx;
  logic [PW-1:0] cand;
  logic [PW-1:0] mem [W];

  logic          rand_ready;
  logic [PW-1:0] pos_out;
  logic [IW-1:0] pos_idx;
  logic          pos_valid;
  logic          busy;
  logic          done;

  logic          accept;
  logic          r_valid;
  logic          r_reject;
  logic [PW-1:0] r;

  assign accept         = bus.rand_valid & rand_ready;
  assign bus.rand_ready = rand_ready;
  assign bus.pos_out    = pos_out;
  assign bus.pos_idx    = pos_idx;
  assign bus.pos_valid  = pos_valid;
  assign bus.busy       = busy;
  assign bus.done       = done;

  // The reducer's first stage register doubles as the latched word a.
  barrett_mod_n #(.parameter_set(parameter_set)) u_reduce (
    .clk     (clk),
    .rst_n   (rst_n),
    .a_valid (accept),
    .a       (bus.rand_in),
    .r_valid (r_valid),
    .r       (r),
    .reject  (r_reject)
  );

  // Stored positions are never cleared; only entries below count are read.
  always_ff @(posedge clk) begin
    if (state == EMIT) mem[count] <= cand;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      count      <= '0;
      chk_idx    <= '0;
      cand       <= '0;
      rand_ready <= 1'b0;
      pos_out    <= '0;
      pos_idx    <= '0;
      pos_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      pos_valid <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start && !done) begin
            count      <= '0;
            busy       <= 1'b1;
            rand_ready <= 1'b1;
            state      <= FETCH;
          end
        end
        FETCH: begin
          if (bus.rand_valid) begin
            rand_ready <= 1'b0;
            state      <= REDUCE;
          end
        end
        REDUCE: begin
          if (r_valid) begin
            if (r_reject) begin
              rand_ready <= 1'b1;
              state      <= FETCH;
            end else begin
              cand    <= r;
              chk_idx <= '0;
              state   <= CHECK;
            end
          end
        end
        // One stored entry compared per cycle; an empty list still spends one cycle.
        CHECK: begin
          if (count != '0 && mem[chk_idx] == cand) begin
            rand_ready <= 1'b1;
            state      <= FETCH;
          end else if (count == '0 || (chk_idx + CW'(1)) == count) begin
            state <= EMIT;
          end else begin
            chk_idx <= chk_idx + CW'(1);
          end
        end
        EMIT: begin
          pos_valid <= 1'b1;
          pos_out   <= cand;
          pos_idx   <= IW'(count);
          count     <= count + CW'(1);
          if (count == CW'(W - 1)) begin
            state <= FIN;
          end else begin
            rand_ready <= 1'b1;
            state      <= FETCH;
          end
        end
        FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_weight_pos_gen.sv
// Directed and randomized bench for fixed_weight_pos_gen (hqc128) against a
// modulo/set-based reference model.
module tb_fixed_weight_pos_gen;
  import hqc_params_pkg::*;

  localparam param_set_e PS = HQC128;
  localparam int unsigned N = set_n(PS);
  localparam int          W = int'(set_w(PS));
  localparam int unsigned K = set_k(PS);

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fixed_weight_pos_gen_if #(.parameter_set(PS)) bus ();

  fixed_weight_pos_gen #(.parameter_set(PS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_assert = 0;
  int n_fail = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  int last_strobe_cyc = -1;
  int dones_expected = 0;

  int unsigned obs_pos[$];
  int unsigned obs_idx[$];
  int unsigned exp_pos[$];
  logic [31:0] words_q[$];
  bit          acc_q[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bus.pos_valid === 1'b1) begin
      obs_pos.push_back(32'(bus.pos_out));
      obs_idx.push_back(32'(bus.pos_idx));
      last_strobe_cyc = cyc;
    end
    if (bus.done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_assert++;
    assert (observed === expected)
      else begin
        n_fail++;
        $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
      end
  endtask

  // Reference: reject biased words, reduce with %, keep only unseen residues.
  function automatic bit modelWord(input logic [31:0] w);
    int unsigned p;
    if (exp_pos.size() >= W) return 1'b0;
    if (64'(w) >= 64'(K) * 64'(N)) return 1'b0;
    p = w % N;
    foreach (exp_pos[i]) if (exp_pos[i] == p) return 1'b0;
    exp_pos.push_back(p);
    return 1'b1;
  endfunction

  function automatic logic [31:0] genWord();
    int unsigned sel;
    int unsigned pick;
    sel = $urandom_range(0, 9);
    if (sel == 0) return 32'hFFFF_FFFF - 32'($urandom_range(0, 4000));
    if (sel == 1 && exp_pos.size() > 0) begin
      pick = $urandom_range(0, exp_pos.size() - 1);
      return 32'(exp_pos[pick] + N * $urandom_range(1, 1000));
    end
    return $urandom;
  endfunction

  function automatic void genList();
    logic [31:0] w;
    words_q.delete();
    acc_q.delete();
    exp_pos.delete();
    while (exp_pos.size() < W) begin
      w = genWord();
      words_q.push_back(w);
      acc_q.push_back(modelWord(w));
    end
  endfunction

  task automatic pulseStart();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Offers one word and returns at the negedge just after it was consumed.
  task automatic applyStimulus(input logic [31:0] word, input bit stall);
    int gap;
    int n;
    if (stall) begin
      gap = $urandom_range(0, 3);
      repeat (gap) begin
        bus.rand_valid = 1'b0;
        bus.rand_in    = $urandom;
        @(negedge clk);
      end
    end
    bus.rand_in    = word;
    bus.rand_valid = 1'b1;
    n = 0;
    while (bus.rand_ready !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (bus.rand_ready !== 1'b1) checkOutput("ready_timeout", 64'(bus.rand_ready), 64'd1);
    @(negedge clk);
    bus.rand_valid = 1'b0;
  endtask

  task automatic waitDone(input string tag);
    int n;
    n = 0;
    while (bus.done !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    dones_expected++;
    checkOutput({tag, "_done_seen"}, 64'(bus.done), 64'd1);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    checkOutput({tag, "_done_gap"}, 64'(done_cyc - last_strobe_cyc), 64'd1);
    checkOutput({tag, "_done_count"}, 64'(done_cnt), 64'(dones_expected));
    checkOutput({tag, "_busy_after_done"}, 64'(bus.busy), 64'd0);
    checkOutput({tag, "_start_on_done_ignored"}, 64'(bus.rand_ready), 64'd0);
  endtask

  task automatic compareAll(input string tag);
    checkOutput({tag, "_strobe_count"}, 64'(obs_pos.size()), 64'(W));
    for (int i = 0; i < W; i++) begin
      if (i < obs_pos.size()) begin
        checkOutput($sformatf("%s_pos%0d", tag, i), 64'(obs_pos[i]), 64'(exp_pos[i]));
        checkOutput($sformatf("%s_idx%0d", tag, i), 64'(obs_idx[i]), 64'(i));
      end
    end
  endtask

  task automatic runVector(input string tag, input bit stall);
    obs_pos.delete();
    obs_idx.delete();
    pulseStart();
    foreach (words_q[i]) applyStimulus(words_q[i], stall);
    waitDone(tag);
    compareAll(tag);
  endtask

  initial begin
    logic [31:0] w;
    logic [31:0] bias_words [2];
    int n;
    int acc;
    int j;
    int dn;

    bus.start      = 1'b0;
    bus.rand_valid = 1'b0;
    bus.rand_in    = '0;
    rst_n          = 1'b0;
    bias_words[0]  = 32'd4294967295;
    bias_words[1]  = 32'd4294962851;

    repeat (3) @(negedge clk);
    checkOutput("reset_rand_ready", 64'(bus.rand_ready), 64'd0);
    checkOutput("reset_pos_valid", 64'(bus.pos_valid), 64'd0);
    checkOutput("reset_busy", 64'(bus.busy), 64'd0);
    checkOutput("reset_done", 64'(bus.done), 64'd0);
    checkOutput("reset_pos_out", 64'(bus.pos_out), 64'd0);
    checkOutput("reset_pos_idx", 64'(bus.pos_idx), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] vector 1: directed words then random fill");
    exp_pos.delete();
    obs_pos.delete();
    obs_idx.delete();
    pulseStart();
    checkOutput("busy_after_start", 64'(bus.busy), 64'd1);
    w = 32'd0;          void'(modelWord(w)); applyStimulus(w, 1'b0);
    w = 32'd100000;     void'(modelWord(w)); applyStimulus(w, 1'b0);
    w = 32'd4294962850; void'(modelWord(w)); applyStimulus(w, 1'b0);
    n = 0;
    while (obs_pos.size() < 3 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("basic_count", 64'(obs_pos.size()), 64'd3);
    checkOutput("basic_pos0", 64'(obs_pos[0]), 64'd0);
    checkOutput("basic_pos1", 64'(obs_pos[1]), 64'd11655);
    checkOutput("basic_pos2", 64'(obs_pos[2]), 64'd17668);
    checkOutput("basic_idx0", 64'(obs_idx[0]), 64'd0);
    checkOutput("basic_idx1", 64'(obs_idx[1]), 64'd1);
    checkOutput("basic_idx2", 64'(obs_idx[2]), 64'd2);

    for (int b = 0; b < 2; b++) begin
      void'(modelWord(bias_words[b]));
      applyStimulus(bias_words[b], 1'b0);
      n = 1;
      while (bus.rand_ready !== 1'b1 && n < 50) begin
        @(negedge clk);
        n++;
      end
      checkOutput($sformatf("bias_ready_latency%0d", b), 64'(n), 64'd4);
    end
    checkOutput("bias_no_strobe", 64'(obs_pos.size()), 64'd3);

    w = 32'd5;     void'(modelWord(w)); applyStimulus(w, 1'b0);
    w = 32'd17674; void'(modelWord(w)); applyStimulus(w, 1'b0);
    n = 0;
    while (bus.rand_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("dup_ready_back", 64'(bus.rand_ready), 64'd1);
    checkOutput("dup_count", 64'(obs_pos.size()), 64'd4);
    checkOutput("dup_pos", 64'(obs_pos[3]), 64'd5);
    checkOutput("dup_idx", 64'(obs_idx[3]), 64'd3);

    pulseStart();
    while (exp_pos.size() < W) begin
      w = genWord();
      void'(modelWord(w));
      applyStimulus(w, 1'b0);
    end
    waitDone("v1");
    compareAll("v1");

    $display("[TB] vector 2/3: same word list stalled then unstalled");
    genList();
    runVector("v2_stall", 1'b1);
    runVector("v3_nostall", 1'b0);

    $display("[TB] vector 4: reset while checking the 11th candidate");
    genList();
    obs_pos.delete();
    obs_idx.delete();
    pulseStart();
    acc = 0;
    j = 0;
    while (j < words_q.size() && !(acc_q[j] && acc == 10)) begin
      if (acc_q[j]) acc++;
      j++;
    end
    for (int i = 0; i < j; i++) applyStimulus(words_q[i], 1'b0);
    applyStimulus(words_q[j], 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("pre_reset_strobes", 64'(obs_pos.size()), 64'd10);
    checkOutput("pre_reset_busy", 64'(bus.busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_busy", 64'(bus.busy), 64'd0);
    checkOutput("async_rst_rand_ready", 64'(bus.rand_ready), 64'd0);
    checkOutput("async_rst_pos_valid", 64'(bus.pos_valid), 64'd0);
    checkOutput("async_rst_done", 64'(bus.done), 64'd0);
    checkOutput("async_rst_pos_out", 64'(bus.pos_out), 64'd0);
    checkOutput("async_rst_pos_idx", 64'(bus.pos_idx), 64'd0);
    dn = done_cnt;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("no_done_after_reset", 64'(done_cnt), 64'(dn));
    checkOutput("idle_after_reset", 64'(bus.busy), 64'd0);

    $display("[TB] vector 5: fresh vector after reset");
    genList();
    runVector("v5_after_reset", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
